video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_pkg.sv | 15 +
 rtl/wrap_counter.sv | 29 ++
 rtl/video_timing_gen.sv | 82 ++++++++
 tb/tb_video_timing_gen.sv | 131 +++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared widths and default 720p timing constants for the video timing generator.
package video_timing_pkg;
   localparam int HCOUNT_W      = 11;
   localparam int VCOUNT_W      = 10;
   localparam int FRAME_COUNT_W = 6;

   localparam int DEF_ACTIVE_H_PIXELS = 1280;
   localparam int DEF_H_FRONT_PORCH   = 110;
   localparam int DEF_H_SYNC_WIDTH    = 40;
   localparam int DEF_H_BACK_PORCH    = 220;
   localparam int DEF_ACTIVE_LINES    = 720;
   localparam int DEF_V_FRONT_PORCH   = 5;
   localparam int DEF_V_SYNC_WIDTH    = 5;
   localparam int DEF_V_BACK_PORCH    = 20;
endpackage

// File: rtl/wrap_counter.sv
// Enabled up-counter that wraps from TERMINAL to 0; resets to TERMINAL so the
// first enabled edge after reset lands on 0. count_next exposes the coming value.
module wrap_counter #(
   parameter int W        = 8,
   parameter int TERMINAL = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] count,
   output logic [W-1:0] count_next,
   output logic         wrap
);
   localparam logic [W-1:0] TERM = W'(TERMINAL);

   always_comb begin
      wrap       = 1'b0;
      count_next = count;
      if (en) begin
         wrap       = (count == TERM);
         count_next = (count == TERM) ? '0 : count + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count <= TERM;
      else        count <= count_next;
   end
endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters plus registered sync/active/frame decodes.
// Define VTG_FRAME_COUNT_EN to build the frame counter; otherwise frame_count_out is 0.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int ACTIVE_H_PIXELS = DEF_ACTIVE_H_PIXELS,
   parameter int H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
   parameter int H_SYNC_WIDTH    = DEF_H_SYNC_WIDTH,
   parameter int H_BACK_PORCH    = DEF_H_BACK_PORCH,
   parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
   parameter int V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
   parameter int V_SYNC_WIDTH    = DEF_V_SYNC_WIDTH,
   parameter int V_BACK_PORCH    = DEF_V_BACK_PORCH
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   output logic [HCOUNT_W-1:0]      hcount_out,
   output logic [VCOUNT_W-1:0]      vcount_out,
   output logic                     hsync_out,
   output logic                     vsync_out,
   output logic                     active_draw_out,
   output logic                     new_frame_out,
   output logic [FRAME_COUNT_W-1:0] frame_count_out
);
   localparam int H_TOTAL  = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
   localparam int V_TOTAL  = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
   localparam int HS_START = ACTIVE_H_PIXELS + H_FRONT_PORCH;
   localparam int HS_END   = HS_START + H_SYNC_WIDTH;
   localparam int VS_START = ACTIVE_LINES + V_FRONT_PORCH;
   localparam int VS_END   = VS_START + V_SYNC_WIDTH;

   logic [HCOUNT_W-1:0] h_next;
   logic [VCOUNT_W-1:0] v_next;
   logic                h_wrap;
   logic                v_wrap_unused;
   logic                hsync_next, vsync_next, active_next, frame_end_next;

   wrap_counter #(.W(HCOUNT_W), .TERMINAL(H_TOTAL - 1)) u_hcount (
      .clk(clk_in), .rst_n(rst_n_in), .en(1'b1),
      .count(hcount_out), .count_next(h_next), .wrap(h_wrap)
   );

   wrap_counter #(.W(VCOUNT_W), .TERMINAL(V_TOTAL - 1)) u_vcount (
      .clk(clk_in), .rst_n(rst_n_in), .en(h_wrap),
      .count(vcount_out), .count_next(v_next), .wrap(v_wrap_unused)
   );

   // Decode the upcoming position so the registered flags line up with the counts.
   always_comb begin
      hsync_next     = 1'b0;
      vsync_next     = 1'b0;
      active_next    = 1'b0;
      frame_end_next = 1'b0;
      hsync_next     = (h_next >= HCOUNT_W'(HS_START)) && (h_next < HCOUNT_W'(HS_END));
      vsync_next     = (v_next >= VCOUNT_W'(VS_START)) && (v_next < VCOUNT_W'(VS_END));
      active_next    = (h_next < HCOUNT_W'(ACTIVE_H_PIXELS)) && (v_next < VCOUNT_W'(ACTIVE_LINES));
      frame_end_next = (h_next == HCOUNT_W'(ACTIVE_H_PIXELS)) && (v_next == VCOUNT_W'(ACTIVE_LINES));
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         hsync_out       <= 1'b0;
         vsync_out       <= 1'b0;
         active_draw_out <= 1'b0;
         new_frame_out   <= 1'b0;
      end else begin
         hsync_out       <= hsync_next;
         vsync_out       <= vsync_next;
         active_draw_out <= active_next;
         new_frame_out   <= frame_end_next;
      end
   end

`ifdef VTG_FRAME_COUNT_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)           frame_count_out <= '0;
      else if (frame_end_next) frame_count_out <= frame_count_out + FRAME_COUNT_W'(1);
   end
`else
   assign frame_count_out = '0;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen using a small raster so many frames fit
// in a short run; expected outputs come from position arithmetic on the cycle index.
module tb_video_timing_gen;
   localparam int AH  = 16;
   localparam int HFP = 3;
   localparam int HSW = 4;
   localparam int HBP = 5;
   localparam int AL  = 8;
   localparam int VFP = 2;
   localparam int VSW = 2;
   localparam int VBP = 3;
   localparam int HT  = AH + HFP + HSW + HBP;
   localparam int VT  = AL + VFP + VSW + VBP;
   localparam int FT  = HT * VT;
   localparam int VW  = 11 + 10 + 4 + 6;

   logic        clk_in;
   logic        rst_n_in;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
   logic        hsync_out, vsync_out, active_draw_out, new_frame_out;
   logic [5:0]  frame_count_out;

   logic [VW-1:0] exp_q[$];
   int t;
   int checks;
   int errors;

   video_timing_gen #(
      .ACTIVE_H_PIXELS(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
      .ACTIVE_LINES(AL), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out),
      .active_draw_out(active_draw_out), .new_frame_out(new_frame_out),
      .frame_count_out(frame_count_out)
   );

   // clock / reset
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   function automatic logic [VW-1:0] reset_vec();
      return {11'(HT - 1), 10'(VT - 1), 4'b0000, 6'd0};
   endfunction

   // Reference: position c cycles after the first post-reset edge.
   function automatic logic [VW-1:0] model(input int c);
      int h, v, p, fc;
      logic hs, vs, act, nf;
      h   = c % HT;
      v   = (c / HT) % VT;
      hs  = (h >= AH + HFP) && (h < AH + HFP + HSW);
      vs  = (v >= AL + VFP) && (v < AL + VFP + VSW);
      act = (h < AH) && (v < AL);
      nf  = (h == AH) && (v == AL);
      p   = AL * HT + AH;
      fc  = 0;
`ifdef VTG_FRAME_COUNT_EN
      if (c >= p) fc = (((c - p) / FT) + 1) % 64;
`endif
      return {11'(h), 10'(v), hs, vs, act, nf, 6'(fc)};
   endfunction

   function automatic logic [VW-1:0] actual_vec();
      return {hcount_out, vcount_out, hsync_out, vsync_out, active_draw_out,
              new_frame_out, frame_count_out};
   endfunction

   task automatic report_cmp(input string name, input logic [VW-1:0] got,
                             input logic [VW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got h=%0d v=%0d hs=%b vs=%b act=%b nf=%b fc=%0d exp h=%0d v=%0d hs=%b vs=%b act=%b nf=%b fc=%0d",
                  name, t, got[30:20], got[19:10], got[9], got[8], got[7], got[6], got[5:0],
                  exp[30:20], exp[19:10], exp[9], exp[8], exp[7], exp[6], exp[5:0]);
      end
   endtask

   // expected-value producer: one entry per clock edge
   always @(posedge clk_in) begin
      if (!rst_n_in) begin
         t = 0;
         exp_q.push_back(reset_vec());
      end else begin
         t = t + 1;
         exp_q.push_back(model(t - 1));
      end
   end

   // monitor
   always @(negedge clk_in) begin
      if (exp_q.size() > 0) report_cmp("cycle", actual_vec(), exp_q.pop_front());
   end

   // driver tasks
   task automatic run_cycles(input int n);
      repeat (n) @(posedge clk_in);
   endtask

   task automatic hold_reset(input int n);
      @(posedge clk_in);
      #2 rst_n_in = 1'b0;
      #1 report_cmp("async_reset", actual_vec(), reset_vec());
      exp_q.delete();
      repeat (n) @(posedge clk_in);
      #2 rst_n_in = 1'b1;
   endtask

   initial begin
      t = 0;
      checks = 0;
      errors = 0;
      rst_n_in = 1'b0;
      repeat (5) @(posedge clk_in);
      #2 rst_n_in = 1'b1;
      // long enough to see the 6-bit frame count wrap
      run_cycles(64 * FT + 2 * FT + 37);
      for (int i = 0; i < 4; i++) begin
         run_cycles($urandom_range(2 * FT, 10));
         hold_reset($urandom_range(4, 1));
      end
      run_cycles(FT + HT + 5);
      @(negedge clk_in);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
